// File: rtl/lbuf_chunker.sv
// lbuf_chunker
//   Consumer side of the lbuf give handshake. Takes one host lbuf descriptor
//   at a time and splits it into PCIe memory-write chunk requests. Each chunk
//   is bounded by the configured max payload and never crosses a 4 KB host
//   boundary. wt_lbuf1/wt_lbuf2 stay high while an lbuf is being chunked or
//   any of its chunks is still outstanding downstream.
//
// Parameters
//   MAX_PAYLOAD_LOG2  largest chunk supported, log2 bytes (9 = 512 B)
//   OUTS_W            width of the per-lbuf outstanding-chunk counters
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rd_lbuf1/2            giver offers lbuf1 / lbuf2
//   wt_lbuf1/2            lbuf still in use (registered)
//   lbuf_addr/len/en/64b  descriptor from the giver (len bits [1:0] ignored)
//   lbuf_dn               one-cycle pulse: all chunks of current lbuf issued
//   cfg_max_payload       PCIe MPS encoding 0=128 B .. 5=4096 B
//   chunk_req/ack         chunk request handshake to the TX TLP engine
//   chunk_addr/len        chunk byte address / length in DW
//   chunk_64b/sel/last    64-bit TLP, owning lbuf, final chunk of its lbuf
//   chunk_cmpl(_sel)      one chunk fully transmitted, and its owning lbuf
//
// Build option
//   LBUF_CHUNKER_STATS_EN  adds stat_chunks (+1 per accepted chunk) and
//                          stat_lbufs (+1 per lbuf_dn), both 32-bit wrapping.
module lbuf_chunker #(
   parameter int unsigned MAX_PAYLOAD_LOG2 = 9,
   parameter int unsigned OUTS_W           = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_lbuf1,
   input  logic        rd_lbuf2,
   output logic        wt_lbuf1,
   output logic        wt_lbuf2,
   input  logic [63:0] lbuf_addr,
   input  logic [31:0] lbuf_len,
   input  logic        lbuf_en,
   input  logic        lbuf64b,
   output logic        lbuf_dn,
   input  logic [2:0]  cfg_max_payload,
   output logic        chunk_req,
   input  logic        chunk_ack,
   output logic [63:0] chunk_addr,
   output logic [10:0] chunk_len,
   output logic        chunk_64b,
   output logic        chunk_sel,
   output logic        chunk_last,
   input  logic        chunk_cmpl,
   input  logic        chunk_cmpl_sel
`ifdef LBUF_CHUNKER_STATS_EN
   ,
   output logic [31:0] stat_chunks,
   output logic [31:0] stat_lbufs
`endif
);

   localparam logic [3:0] MPS_CAP = 4'(MAX_PAYLOAD_LOG2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_REQ,
      ST_DONE,
      ST_WLOW
   } state_t;

   state_t              state_q, state_d;
   logic [63:0]         addr_q, addr_d;
   logic [31:0]         rem_q, rem_d;
   logic                b64_q, b64_d;
   logic                sel_q, sel_d;
   logic [12:0]         clen_q, clen_d;
   logic [63:0]         c_addr_q, c_addr_d;
   logic [10:0]         c_len_q, c_len_d;
   logic                c_last_q, c_last_d;
   logic [OUTS_W-1:0]   cnt_q [2];
   logic [OUTS_W-1:0]   cnt_d [2];
   logic [1:0]          wt_q, wt_d;

   logic                req_ok;
   logic                hs;
   logic [3:0]          mps_sum;
   logic [3:0]          mps;
   logic [12:0]         mps_bytes;
   logic [12:0]         bdry;
   logic [12:0]         lim;
   logic [12:0]         clen;
   logic [31:0]         len_al;
   logic                unused_ok;

   // rd_lbuf2 alone selects the lbuf; rd_lbuf1 is implied by its absence
   always_comb unused_ok = rd_lbuf1;

   // A request is held off while its lbuf already has the maximum number of
   // chunks in flight.
   always_comb begin
      req_ok    = (cnt_q[sel_q] != '1);
      chunk_req = (state_q == ST_REQ) && req_ok;
      hs        = chunk_req && chunk_ack;
      lbuf_dn   = (state_q == ST_DONE);
   end

   // Chunk size: min(remaining, max payload, bytes left before 4 KB line)
   always_comb begin
      mps_sum   = 4'd7 + {1'b0, cfg_max_payload};
      mps       = (mps_sum > MPS_CAP) ? MPS_CAP : mps_sum;
      mps_bytes = 13'd1 << mps;
      bdry      = 13'h1000 - {1'b0, addr_q[11:0]};
      lim       = (mps_bytes < bdry) ? mps_bytes : bdry;
      clen      = (rem_q < {19'd0, lim}) ? rem_q[12:0] : lim;
      len_al    = lbuf_len & ~32'd3;
   end

   always_comb begin
      logic inc;
      logic dec;
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      b64_d    = b64_q;
      sel_d    = sel_q;
      clen_d   = clen_q;
      c_addr_d = c_addr_q;
      c_len_d  = c_len_q;
      c_last_d = c_last_q;
      inc      = 1'b0;
      dec      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lbuf_en) begin
               addr_d  = lbuf_addr;
               rem_d   = len_al;
               b64_d   = lbuf64b;
               sel_d   = rd_lbuf2;
               state_d = (len_al == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            clen_d   = clen;
            c_addr_d = addr_q;
            c_len_d  = 11'(clen >> 2);
            c_last_d = (rem_q == {19'd0, clen});
            state_d  = ST_REQ;
         end
         ST_REQ: begin
            if (hs) begin
               addr_d  = addr_q + 64'(clen_q);
               rem_d   = rem_q - 32'(clen_q);
               state_d = c_last_q ? ST_DONE : ST_CALC;
            end
         end
         ST_DONE: state_d = ST_WLOW;
         // Giver drops lbuf_en a cycle after lbuf_dn; wait for that so the
         // stale descriptor is not accepted a second time.
         ST_WLOW: begin
            if (!lbuf_en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A simultaneous issue and completion on one lbuf cancel out; a
      // completion against an empty counter is dropped.
      for (int unsigned i = 0; i < 2; i++) begin
         inc      = hs && (sel_q == 1'(i));
         dec      = chunk_cmpl && (chunk_cmpl_sel == 1'(i));
         cnt_d[i] = cnt_q[i];
         if (inc && !dec)
            cnt_d[i] = cnt_q[i] + OUTS_W'(1);
         else if (!inc && dec && (cnt_q[i] != '0))
            cnt_d[i] = cnt_q[i] - OUTS_W'(1);
         wt_d[i]  = (cnt_d[i] != '0) || ((state_d != ST_IDLE) && (sel_d == 1'(i)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         b64_q    <= 1'b0;
         sel_q    <= 1'b0;
         clen_q   <= '0;
         c_addr_q <= '0;
         c_len_q  <= '0;
         c_last_q <= 1'b0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
         wt_q     <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         b64_q    <= b64_d;
         sel_q    <= sel_d;
         clen_q   <= clen_d;
         c_addr_q <= c_addr_d;
         c_len_q  <= c_len_d;
         c_last_q <= c_last_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
         wt_q     <= wt_d;
      end
   end

   always_comb begin
      wt_lbuf1   = wt_q[0];
      wt_lbuf2   = wt_q[1];
      chunk_addr = c_addr_q;
      chunk_len  = c_len_q;
      chunk_64b  = b64_q;
      chunk_sel  = sel_q;
      chunk_last = c_last_q;
   end

`ifdef LBUF_CHUNKER_STATS_EN
   logic [31:0] stat_chunks_q, stat_chunks_d;
   logic [31:0] stat_lbufs_q, stat_lbufs_d;

   always_comb begin
      stat_chunks_d = stat_chunks_q + (hs ? 32'd1 : 32'd0);
      stat_lbufs_d  = stat_lbufs_q + (lbuf_dn ? 32'd1 : 32'd0);
      stat_chunks   = stat_chunks_q;
      stat_lbufs    = stat_lbufs_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_chunks_q <= '0;
         stat_lbufs_q  <= '0;
      end else begin
         stat_chunks_q <= stat_chunks_d;
         stat_lbufs_q  <= stat_lbufs_d;
      end
   end
`endif

endmodule

// File: tb/tb_lbuf_chunker.sv
// Bench for lbuf_chunker: transaction-level model (descriptor split into an
// expected chunk queue, per-lbuf outstanding counts, event-time expectations)
// checked every cycle, plus literal expectations for the directed cases.
module tb_lbuf_chunker;

   localparam int unsigned OUTS_W  = 2;
   localparam int unsigned MPL2    = 9;
   localparam int          CNT_MAX = (1 << OUTS_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_lbuf1 = 1'b0, rd_lbuf2 = 1'b0;
   logic        wt_lbuf1, wt_lbuf2;
   logic [63:0] lbuf_addr = '0;
   logic [31:0] lbuf_len = '0;
   logic        lbuf_en = 1'b0, lbuf64b = 1'b0;
   logic        lbuf_dn;
   logic [2:0]  cfg_max_payload = '0;
   logic        chunk_req;
   logic        chunk_ack = 1'b0;
   logic [63:0] chunk_addr;
   logic [10:0] chunk_len;
   logic        chunk_64b, chunk_sel, chunk_last;
   logic        chunk_cmpl, chunk_cmpl_sel;

   logic man_cmpl = 1'b0, man_sel = 1'b0;
   logic auto_cmpl = 1'b0, auto_sel = 1'b0;
   bit   auto_en = 1'b0;
   bit   mon_en = 1'b0;

   assign chunk_cmpl     = man_cmpl | auto_cmpl;
   assign chunk_cmpl_sel = man_cmpl ? man_sel : auto_sel;

   always #5 clk = ~clk;

   lbuf_chunker #(.MAX_PAYLOAD_LOG2(MPL2), .OUTS_W(OUTS_W)) dut (
      .clk(clk), .rst(rst),
      .rd_lbuf1(rd_lbuf1), .rd_lbuf2(rd_lbuf2),
      .wt_lbuf1(wt_lbuf1), .wt_lbuf2(wt_lbuf2),
      .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len), .lbuf_en(lbuf_en),
      .lbuf64b(lbuf64b), .lbuf_dn(lbuf_dn),
      .cfg_max_payload(cfg_max_payload),
      .chunk_req(chunk_req), .chunk_ack(chunk_ack),
      .chunk_addr(chunk_addr), .chunk_len(chunk_len),
      .chunk_64b(chunk_64b), .chunk_sel(chunk_sel), .chunk_last(chunk_last),
      .chunk_cmpl(chunk_cmpl), .chunk_cmpl_sel(chunk_cmpl_sel)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [63:0] addr;
      logic [10:0] len;
      logic        last;
   } chunk_t;

   chunk_t mq[$];
   int     cyc = 0;
   int     phase = 0;          // 0 idle, 1 chunking, 2 waiting for en low
   logic   m_sel = 1'b0, m_64 = 1'b0;
   int     m_ready = 0, m_dn = -1;
   int     m_cnt [2] = '{0, 0};
   logic [1:0] m_wt = '0;

   // observations for literal checks
   logic [63:0] obs_addr[$];
   logic [10:0] obs_len[$];
   logic        obs_last[$];
   logic        obs_sel[$];
   logic        obs_64[$];
   int          obs_cyc[$];
   int          obs_dn = 0;
   int          dn_cyc = 0;

   function automatic void split(input logic [63:0] a, input logic [31:0] len, input int cfg);
      longint unsigned rem, lim, b, c;
      int mps;
      rem = longint'(len) & ~64'd3;
      mps = 7 + cfg;
      if (mps > int'(MPL2)) mps = int'(MPL2);
      while (rem > 0) begin
         lim = 64'd1 << mps;
         b   = 4096 - (a % 64'd4096);
         c   = rem;
         if (lim < c) c = lim;
         if (b < c) c = b;
         mq.push_back('{addr: a, len: 11'(c / 4), last: (c == rem)});
         a   = a + c;
         rem = rem - c;
      end
   endfunction

   always @(negedge clk) begin
      bit exp_req, exp_dn, hs, inc, dec;
      chunk_t h;
      cyc++;
      exp_req = (phase == 1) && (mq.size() > 0) && (cyc >= m_ready) && (m_cnt[m_sel] != CNT_MAX);
      exp_dn  = (phase == 1) && (cyc == m_dn);
      if (mon_en) begin
         chk("chunk_req", 64'(chunk_req), 64'(exp_req));
         chk("lbuf_dn", 64'(lbuf_dn), 64'(exp_dn));
         chk("wt_lbuf", 64'({wt_lbuf2, wt_lbuf1}), 64'(m_wt));
         if (exp_req && chunk_req) begin
            h = mq[0];
            chk("chunk_addr", chunk_addr, h.addr);
            chk("chunk_len", 64'(chunk_len), 64'(h.len));
            chk("chunk_last", 64'(chunk_last), 64'(h.last));
            chk("chunk_sel", 64'(chunk_sel), 64'(m_sel));
            chk("chunk_64b", 64'(chunk_64b), 64'(m_64));
         end
      end
      if (chunk_req === 1'b1 && chunk_ack === 1'b1) begin
         obs_addr.push_back(chunk_addr);
         obs_len.push_back(chunk_len);
         obs_last.push_back(chunk_last);
         obs_sel.push_back(chunk_sel);
         obs_64.push_back(chunk_64b);
         obs_cyc.push_back(cyc);
      end
      if (lbuf_dn === 1'b1) begin
         obs_dn++;
         dn_cyc = cyc;
      end

      if (rst) begin
         phase = 0;
         mq.delete();
         m_cnt = '{0, 0};
         m_wt  = '0;
         m_dn  = -1;
      end else begin
         hs = exp_req && chunk_ack;
         for (int i = 0; i < 2; i++) begin
            inc = hs && (m_sel == 1'(i));
            dec = chunk_cmpl && (chunk_cmpl_sel == 1'(i));
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
         end
         if (hs) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_dn = cyc + 1;
            else m_ready = cyc + 2;
         end
         case (phase)
            0: if (lbuf_en) begin
                  m_sel = rd_lbuf2;
                  m_64  = lbuf64b;
                  split(lbuf_addr, lbuf_len, int'(cfg_max_payload));
                  phase = 1;
                  if (mq.size() == 0) m_dn = cyc + 1;
                  else m_ready = cyc + 2;
               end
            1: if (cyc == m_dn) phase = 2;
            default: if (!lbuf_en) phase = 0;
         endcase
         for (int i = 0; i < 2; i++)
            m_wt[i] = (m_cnt[i] != 0) || (phase != 0 && m_sel == 1'(i));
      end
   end

   // completes every accepted chunk one cycle after it is accepted
   initial forever begin
      logic s;
      @(negedge clk);
      if (auto_en && chunk_req === 1'b1 && chunk_ack === 1'b1 && !rst) begin
         s = chunk_sel;
         @(posedge clk); #1;
         auto_cmpl = 1'b1;
         auto_sel  = s;
         @(posedge clk); #1;
         auto_cmpl = 1'b0;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic obs_clear();
      obs_addr.delete(); obs_len.delete(); obs_last.delete();
      obs_sel.delete(); obs_64.delete(); obs_cyc.delete();
      obs_dn = 0;
   endtask

   task automatic give(input logic [63:0] a, input logic [31:0] len, input logic b64,
                       input logic sel2, input logic [2:0] cfg);
      lbuf_addr       = a;
      lbuf_len        = len;
      lbuf64b         = b64;
      rd_lbuf1        = ~sel2;
      rd_lbuf2        = sel2;
      cfg_max_payload = cfg;
      lbuf_en         = 1'b1;
   endtask

   task automatic wait_dn(input string name);
      bit found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick();
         if (lbuf_dn) found = 1;
      end
      if (!found) chk({name, "_dn_timeout"}, 64'd0, 64'd1);
      tick();
      lbuf_en  = 1'b0;
      rd_lbuf1 = 1'b0;
      rd_lbuf2 = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      chunk_ack = 1'b1;
      repeat (3) tick();
      mon_en = 1;
      chk("rst_req", 64'(chunk_req), 64'd0);
      chk("rst_dn", 64'(lbuf_dn), 64'd0);
      chk("rst_wt", 64'({wt_lbuf2, wt_lbuf1}), 64'd0);
      chk("rst_addr", chunk_addr, 64'd0);
      chk("rst_len", 64'(chunk_len), 64'd0);
      rst = 1'b0;
      tick();

      // 1: eight 32 DW chunks at 0x1000..0x1380
      obs_clear(); auto_en = 1;
      give(64'h1000, 32'd1024, 1'b0, 1'b0, 3'd0);
      wait_dn("t1");
      chk("t1_n", 64'(obs_addr.size()), 64'd8);
      if (obs_addr.size() == 8) begin
         chk("t1_a0", obs_addr[0], 64'h1000);
         chk("t1_a7", obs_addr[7], 64'h1380);
         chk("t1_l0", 64'(obs_len[0]), 64'd32);
         chk("t1_l7", 64'(obs_len[7]), 64'd32);
         chk("t1_last6", 64'(obs_last[6]), 64'd0);
         chk("t1_last7", 64'(obs_last[7]), 64'd1);
         chk("t1_dn_lat", 64'(dn_cyc - obs_cyc[7]), 64'd1);
      end
      chk("t1_dn_cnt", 64'(obs_dn), 64'd1);

      // 2: 4 KB split
      obs_clear();
      give(64'hF80, 32'd512, 1'b0, 1'b0, 3'd2);
      wait_dn("t2");
      chk("t2_n", 64'(obs_addr.size()), 64'd2);
      if (obs_addr.size() == 2) begin
         chk("t2_a0", obs_addr[0], 64'hF80);
         chk("t2_l0", 64'(obs_len[0]), 64'd32);
         chk("t2_a1", obs_addr[1], 64'h1000);
         chk("t2_l1", 64'(obs_len[1]), 64'd96);
      end

      // 3: 64-bit address, lbuf2
      obs_clear();
      give(64'h1_0000_0000, 32'd256, 1'b1, 1'b1, 3'd1);
      wait_dn("t3");
      chk("t3_n", 64'(obs_addr.size()), 64'd1);
      if (obs_addr.size() == 1) begin
         chk("t3_a0", obs_addr[0], 64'h1_0000_0000);
         chk("t3_l0", 64'(obs_len[0]), 64'd64);
         chk("t3_sel", 64'(obs_sel[0]), 64'd1);
         chk("t3_64b", 64'(obs_64[0]), 64'd1);
         chk("t3_last", 64'(obs_last[0]), 64'd1);
      end

      // 4: zero length
      obs_clear();
      give(64'h3000, 32'd0, 1'b0, 1'b0, 3'd0);
      wait_dn("t4");
      chk("t4_n", 64'(obs_addr.size()), 64'd0);
      chk("t4_dn_cnt", 64'(obs_dn), 64'd1);
      chk("t4_wt1", 64'(wt_lbuf1), 64'd0);

      // 5: outstanding limit of 3 with no completions
      obs_clear(); auto_en = 0;
      give(64'h2000, 32'd1024, 1'b0, 1'b0, 3'd0);
      repeat (20) tick();
      chk("t5_stall_n", 64'(obs_addr.size()), 64'd3);
      chk("t5_wt1", 64'(wt_lbuf1), 64'd1);
      for (int k = 0; k < 5; k++) begin
         man_cmpl = 1'b1; man_sel = 1'b0;
         tick();
         man_cmpl = 1'b0;
         repeat (6) tick();
         chk("t5_release_n", 64'(obs_addr.size()), 64'(4 + k));
      end
      chk("t5_dn_cnt", 64'(obs_dn), 64'd1);
      lbuf_en = 1'b0; rd_lbuf1 = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         man_cmpl = 1'b1; man_sel = 1'b0;
         tick();
         man_cmpl = 1'b0;
         repeat (3) tick();
         chk("t5_wt1_drain", 64'(wt_lbuf1), (k < 2) ? 64'd1 : 64'd0);
      end

      // 6: reset mid-lbuf, then a fresh lbuf
      obs_clear(); auto_en = 1;
      give(64'h4000, 32'd512, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 100 && obs_addr.size() < 2; i++) tick();
      chk("t6_acks_before_rst", 64'(obs_addr.size()), 64'd2);
      rst = 1'b1; lbuf_en = 1'b0; rd_lbuf1 = 1'b0;
      tick();
      rst = 1'b0;
      chk("t6_wt1_after_rst", 64'(wt_lbuf1), 64'd0);
      chk("t6_req_after_rst", 64'(chunk_req), 64'd0);
      repeat (10) tick();
      chk("t6_no_dn", 64'(obs_dn), 64'd0);
      chk("t6_no_more_acks", 64'(obs_addr.size()), 64'd2);
      obs_clear();
      give(64'h5000, 32'd256, 1'b0, 1'b0, 3'd0);
      wait_dn("t6b");
      chk("t6b_n", 64'(obs_addr.size()), 64'd2);
      if (obs_addr.size() == 2) begin
         chk("t6b_a0", obs_addr[0], 64'h5000);
         chk("t6b_a1", obs_addr[1], 64'h5080);
      end
      chk("t6b_dn_cnt", 64'(obs_dn), 64'd1);

      repeat (5) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
